// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster pixel stream to 3x3 Sobel window generator
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        sof_in,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid_in,
    output logic [71:0] pixel_data_out,
    output logic        pixel_data_valid_out,
    output logic        frame_done_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [7:0]      r_lb0 [IMG_WIDTH];
    logic [7:0]      r_lb1 [IMG_WIDTH];
    logic [8:0][7:0] r_win;
    logic            r_valid;
    logic            r_done;

    logic            w_sof;
    logic            w_acc;
    logic [CW-1:0]   w_c;
    logic [RW-1:0]   w_r;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic            w_last_col;
    logic            w_last_pix;

    // A qualified sof always wins and redefines the current pixel as (0,0).
    assign w_sof      = sof_in & pixel_valid_in;
    assign w_acc      = pixel_valid_in & (w_sof | (r_state != IDLE));
    assign w_c        = w_sof ? '0 : r_col;
    assign w_r        = w_sof ? '0 : r_row;
    assign w_a        = r_lb0[w_c];
    assign w_b        = r_lb1[w_c];
    assign w_last_col = (w_c == COL_LAST);
    assign w_last_pix = (r_state == STREAM) & !w_sof & w_last_col & (w_r == ROW_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_sof) begin
            w_next_state = FILL;
        end else if (w_acc) begin
            case (r_state)
                FILL:    if (w_last_col && (w_r == ROW_ONE)) w_next_state = STREAM;
                STREAM:  if (w_last_pix) w_next_state = IDLE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= (w_r == ROW_LAST) ? '0 : w_r + 1'b1;
            end else begin
                r_col <= w_c + 1'b1;
                r_row <= w_r;
            end
        end
    end

    // Line buffers hold rows r-2 and r-1; contents need no reset.
    always_ff @(posedge Clk) begin
        if (w_acc) begin
            r_lb0[w_c] <= w_b;
            r_lb1[w_c] <= pixel_in;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_win   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_acc & !w_sof & (r_state == STREAM) & (w_c >= COL_TWO);
            r_done  <= w_acc & w_last_pix;
            if (w_acc) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_a;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_b;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pixel_in;
            end
        end
    end

    assign pixel_data_out       = r_win;
    assign pixel_data_valid_out = r_valid;
    assign frame_done_out       = r_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;
    localparam logic [71:0] S1_FIRST = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] S1_LAST  = 72'h34_33_32_24_23_22_14_13_12;
    localparam logic [71:0] F2_FIRST = 72'hA2_A1_A0_92_91_90_82_81_80;
    localparam logic [71:0] F2_LAST  = 72'hB4_B3_B2_A4_A3_A2_94_93_92;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        sof_in = 1'b0;
    logic [7:0]  pixel_in = 8'h00;
    logic        pixel_valid_in = 1'b0;
    logic [71:0] pixel_data_out;
    logic        pixel_data_valid_out;
    logic        frame_done_out;

    int n_checks = 0;
    int n_errors = 0;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .Clk                  (Clk),
        .Rst_n                (Rst_n),
        .sof_in               (sof_in),
        .pixel_in             (pixel_in),
        .pixel_valid_in       (pixel_valid_in),
        .pixel_data_out       (pixel_data_out),
        .pixel_data_valid_out (pixel_data_valid_out),
        .frame_done_out       (frame_done_out)
    );

    always #5 Clk = ~Clk;

    // Reference model: stores the accepted image and cuts windows from it.
    logic [7:0]  img [0:H-1][0:W-1];
    int          m_r = 0;
    int          m_c = 0;
    logic        m_in = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_done = 1'b0;
    logic [71:0] exp_data = '0;
    int          cur_r;
    int          cur_c;
    logic        m_acc;

    assign m_acc = pixel_valid_in && (sof_in || m_in);
    assign cur_r = sof_in ? 0 : m_r;
    assign cur_c = sof_in ? 0 : m_c;

    function automatic logic [71:0] model_win(int r, int c, logic [7:0] p);
        logic [71:0] w;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = img[r-2+k/3][c-2+k%3];
        w[71:64] = p;
        return w;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
            exp_data  <= '0;
            m_in      <= 1'b0;
            m_r       <= 0;
            m_c       <= 0;
        end else begin
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
            if (m_acc) begin
                img[cur_r][cur_c] <= pixel_in;
                if (cur_r >= 2 && cur_c >= 2) begin
                    exp_valid <= 1'b1;
                    exp_data  <= model_win(cur_r, cur_c, pixel_in);
                end
                if (cur_r == H-1 && cur_c == W-1) begin
                    exp_done <= 1'b1;
                    m_in     <= 1'b0;
                    m_r      <= 0;
                    m_c      <= 0;
                end else begin
                    m_in <= 1'b1;
                    m_r  <= (cur_c == W-1) ? cur_r + 1 : cur_r;
                    m_c  <= (cur_c == W-1) ? 0 : cur_c + 1;
                end
            end
        end
    end

    logic [71:0] win [0:15];
    int          win_cnt = 0;
    int          done_cnt = 0;
    logic [71:0] done_win = '0;

    always @(negedge Clk) begin
        n_checks++;
        if (pixel_data_valid_out !== exp_valid) begin
            n_errors++;
            $display("FAIL valid_cyc t=%0t got %b exp %b", $time, pixel_data_valid_out, exp_valid);
        end
        n_checks++;
        if (frame_done_out !== exp_done) begin
            n_errors++;
            $display("FAIL done_cyc t=%0t got %b exp %b", $time, frame_done_out, exp_done);
        end
        if (exp_valid) begin
            n_checks++;
            if (pixel_data_out !== exp_data) begin
                n_errors++;
                $display("FAIL window_cyc t=%0t got %h exp %h", $time, pixel_data_out, exp_data);
            end
        end
        if (pixel_data_valid_out === 1'b1) begin
            if (win_cnt < 16) win[win_cnt] = pixel_data_out;
            win_cnt++;
        end
        if (frame_done_out === 1'b1) begin
            done_cnt++;
            done_win = pixel_data_out;
        end
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] p);
        @(posedge Clk);
        #2;
        sof_in = s;
        pixel_valid_in = v;
        pixel_in = p;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_pixels(input logic [7:0] base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            drive(i == 0, 1'b1, base + 8'((i / W) * 16 + (i % W)));
            if (gap) drive(1'b0, 1'b0, 8'hEE);
        end
    endtask

    task automatic clear_stats();
        win_cnt  = 0;
        done_cnt = 0;
        done_win = '0;
    endtask

    task automatic check_frame(input string name, input logic [71:0] first, input logic [71:0] last);
        check({name, "_count"}, 72'(win_cnt), 72'd6);
        check({name, "_dones"}, 72'(done_cnt), 72'd1);
        check({name, "_first"}, win[0], first);
        check({name, "_last"}, win[5], last);
        check({name, "_done_win"}, done_win, last);
    endtask

    initial begin
        #1;
        check("reset_data", pixel_data_out, '0);
        check("reset_valid", 72'(pixel_data_valid_out), 72'd0);
        check("reset_done", 72'(frame_done_out), 72'd0);
        #12 Rst_n = 1'b1;

        // Continuous full frame
        settle(1);
        clear_stats();
        send_pixels(8'h00, W*H, 1'b0);
        settle(3);
        check_frame("s1", S1_FIRST, S1_LAST);

        // Valid toggling every cycle
        clear_stats();
        send_pixels(8'h00, W*H, 1'b1);
        settle(3);
        check_frame("s2", S1_FIRST, S1_LAST);

        // Pixels without sof in IDLE are dropped
        clear_stats();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h55);
        send_pixels(8'h00, W*H, 1'b0);
        settle(3);
        check_frame("s3", S1_FIRST, S1_LAST);

        // Frame 1 aborted at (2,3) by a new sof
        clear_stats();
        send_pixels(8'h00, 2*W + 3, 1'b0);
        settle(2);
        check("s4_f1_count", 72'(win_cnt), 72'd1);
        clear_stats();
        send_pixels(8'h80, W*H, 1'b0);
        settle(3);
        check_frame("s4", F2_FIRST, F2_LAST);

        // Asynchronous reset mid-row 2 while a window is valid
        send_pixels(8'h00, 2*W + 4, 1'b0);
        @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        check("s5_rst_data", pixel_data_out, '0);
        check("s5_rst_valid", 72'(pixel_data_valid_out), 72'd0);
        check("s5_rst_done", 72'(frame_done_out), 72'd0);
        @(posedge Clk);
        @(posedge Clk);
        #3 Rst_n = 1'b1;
        settle(1);
        clear_stats();
        send_pixels(8'h00, W*H, 1'b0);
        settle(3);
        check_frame("s5", S1_FIRST, S1_LAST);

        // Back-to-back frames, no idle cycle
        clear_stats();
        send_pixels(8'h00, W*H, 1'b0);
        send_pixels(8'h80, W*H, 1'b0);
        settle(3);
        check("s6_count", 72'(win_cnt), 72'd12);
        check("s6_dones", 72'(done_cnt), 72'd2);
        check("s6_f1_first", win[0], S1_FIRST);
        check("s6_f1_last", win[5], S1_LAST);
        check("s6_f2_first", win[6], F2_FIRST);
        check("s6_f2_last", win[11], F2_LAST);
        check("s6_done_win", done_win, F2_LAST);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Converts a raster pixel stream (one 8-bit pixel per valid cycle) into 3x3 neighbourhood windows for the Sobel convolution stage.
- Uses two on-chip line buffers plus a 3x3 register window.
- Emits one packed 72-bit window per input pixel once the window lies fully inside the image (no border padding).
- Sits directly upstream of the Sobel convolution block; its window output and window-valid connect straight to that block's pixel inputs.

Parameters:
- IMG_WIDTH, 640, pixels per line (>= 3).
- IMG_HEIGHT, 480, lines per frame (>= 3).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- sof_in  in  1  start of frame; qualified by pixel_valid_in, marks pixel (0,0).
- pixel_in  in  8  unsigned pixel, raster order.
- pixel_valid_in  in  1  pixel_in valid this cycle; no backpressure.
- pixel_data_out  out  72  3x3 window. Slot i = bits [i*8+7 : i*8], row-major, slot 0 top-left.
- pixel_data_valid_out  out  1  pixel_data_out holds a complete in-image window.
- frame_done_out  out  1  one-cycle pulse, aligned with the last window of the frame.

Behaviour:
- Reset:
  - One clock, asynchronous active-low reset (Rst_n); all registers clear immediately on Rst_n low.
  - pixel_data_out=0, pixel_data_valid_out=0, frame_done_out=0, col=0, row=0, state=IDLE.
  - Line-buffer RAM contents are not reset; they are don't-care.
- Counters:
  - col runs 0..IMG_WIDTH-1; row runs 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels; col wraps to 0 and increments row.
- State machine:
  - IDLE: pixels are dropped unless sof_in=1 & pixel_valid_in=1; that pixel is accepted as (0,0), next state FILL.
  - FILL: rows 0-1 are accepted; no window output. On the last pixel of row 1, go to STREAM.
  - STREAM: rows 2..IMG_HEIGHT-1. On pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to IDLE.
  - In any state, sof_in=1 & pixel_valid_in=1 restarts the frame: that pixel becomes (0,0), state=FILL, no frame_done_out pulse for the aborted frame.
  - sof_in without pixel_valid_in is ignored.
- Line buffers:
  - lb0 and lb1 are IMG_WIDTH x 8 each.
  - On an accepted pixel at column c: read a=lb0[c] (row r-2) and b=lb1[c] (row r-1), then write lb0[c]<=b and lb1[c]<=pixel_in, all in the same cycle.
- Window registers:
  - On an accepted pixel, each window row shifts left one column and the new right column is loaded: slot2<=a, slot5<=b, slot8<=pixel_in.
  - Also slot0<=slot1, slot1<=slot2, and so on for each row.
  - pixel_data_out is driven directly from the window registers.
- Valid and latency:
  - pixel_data_valid_out<=accepted & state==STREAM-row (row>=2) & col>=2, registered.
  - Window and valid appear 1 cycle after the completing input pixel.
  - Window content for input (r,c): slot0=(r-2,c-2) … slot8=(r,c).
- Frame completion:
  - frame_done_out pulses in the same cycle as the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Valid gaps: when pixel_valid_in=0, counters, buffers and window hold. Valid out drops to 0; pixel_data_out holds its last value.
- Columns 0-1 of each row: window contents are stale from the previous row and are never flagged valid.
- Reset mid-frame: returns to IDLE; the next frame requires sof_in.

Test Plan (bench uses IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col):
- Full frame, continuous valid with sof on first pixel -> exactly 6 valid windows. First window, one cycle after pixel (2,2), is pixel_data_out=72'h22_21_20_12_11_10_02_01_00. Last window = 72'h34_33_32_24_23_22_14_13_12 with frame_done_out=1 in the same cycle.
- Same frame with pixel_valid_in toggling 1/0 each cycle -> identical 6 windows in identical order; valid only on the cycle after each accepted pixel; frame_done_out occurs once.
- Pixels sent without sof_in in IDLE, then a proper frame -> leading pixels ignored; window output matches scenario 1.
- sof_in reasserted at pixel (2,3) of frame 1, then a full frame 2 with values +0x80 -> no frame_done_out for frame 1. Frame 2 yields 6 windows, first = 72'hA2_A1_A0_92_91_90_82_81_80.
- Rst_n pulsed low asynchronously mid-row 2 -> outputs 0 immediately; following sof-started frame reproduces scenario 1 exactly.
- Two back-to-back frames with no idle cycle -> 12 windows, two frame_done_out pulses; the second frame's first window contains no data from frame 1.
